// File: rtl/lsu_pkg.sv
// Shared constants and FSM encoding for the load/store unit that fronts the word-only ram.
package lsu_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_MERGE  = 2'b10,
      ST_RESP   = 2'b11
   } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Lane datapath: picks and extends the addressed byte/half of a read word for loads,
// and splices store data into the addressed lane of a read word for sub-word stores.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  offset_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merge_o
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane select, extension and merge for the latched access size.
   always_comb begin
      byte_s  = rdata_i[{offset_i, 3'b000} +: 8];
      half_s  = rdata_i[{offset_i[1], 4'b0000} +: 16];
      load_o  = rdata_i;
      merge_o = rdata_i;
      case (size_i)
         SIZE_BYTE: begin
            load_o = unsigned_i ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
            merge_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
         end
         SIZE_HALF: begin
            load_o = unsigned_i ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
            merge_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
         end
         default: begin
            load_o  = rdata_i;
            merge_o = wdata_i;
         end
      endcase
   end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit: turns byte/half/word requests into whole-word ram accesses,
// using read-modify-write for sub-word stores, with alignment and range faulting.
module lsu_rmw
   import lsu_pkg::*;
#(
   parameter int unsigned RAM_SIZE = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [29:0] RAM_WORDS = 30'(RAM_SIZE);

   lsu_state_e  state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_fault_q, rsp_fault_d;

   logic        fault_s;
   logic [31:0] load_s;
   logic [31:0] merge_s;

   lsu_align u_align (
      .rdata_i   (mem_rdata),
      .offset_i  (addr_q[1:0]),
      .size_i    (size_q),
      .unsigned_i(uns_q),
      .wdata_i   (wdata_q),
      .load_o    (load_s),
      .merge_o   (merge_s)
   );

   // Fault check on the incoming request; word index at or above RAM_SIZE never reaches the ram.
   always_comb begin
      fault_s = (req_size == SIZE_RSVD)
              | ((req_size == SIZE_HALF) & req_addr[0])
              | ((req_size == SIZE_WORD) & (req_addr[1:0] != 2'b00))
              | (req_addr[31:2] >= RAM_WORDS);
   end

   // Next-state and registered-output decode.
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      size_d      = size_q;
      uns_d       = uns_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      mem_we_d    = 1'b0;
      mem_wdata_d = mem_wdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = 32'h0000_0000;
      rsp_fault_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               size_d  = req_size;
               uns_d   = req_unsigned;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               if (fault_s) begin
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_fault_d = 1'b1;
               end else begin
                  state_d = ST_ACCESS;
                  // Full-word stores write straight away in ACCESS, no read needed.
                  if (req_we && (req_size == SIZE_WORD)) begin
                     mem_we_d    = 1'b1;
                     mem_wdata_d = req_wdata;
                  end else begin
                     mem_we_d = 1'b0;
                  end
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (!we_q) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = load_s;
            end else if (size_q == SIZE_WORD) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
            end else begin
               state_d     = ST_MERGE;
               mem_we_d    = 1'b1;
               mem_wdata_d = merge_s;
            end
         end
         ST_MERGE: begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and latched request registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         we_q        <= 1'b0;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         addr_q      <= 32'h0000_0000;
         wdata_q     <= 32'h0000_0000;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= 32'h0000_0000;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0000_0000;
         rsp_fault_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_fault_q <= rsp_fault_d;
      end
   end

   // A reset arriving during the write cycle must suppress that write, hence the rst gate.
   assign mem_we    = mem_we_q & ~rst;
   assign mem_addr  = {addr_q[31:2], 2'b00};
   assign mem_wdata = mem_wdata_q;
   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw with an attached 32-word ram and a request-level reference model.
module tb_lsu_rmw;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   lsu_rmw #(.RAM_SIZE(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_size    (req_size),
      .req_unsigned(req_unsigned),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_fault   (rsp_fault),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Attached ram: combinational read, write on posedge; preloaded once.
   logic [31:0] ram [0:31];
   logic        ram_loaded = 1'b0;
   always @(posedge clk) begin
      if (!ram_loaded) begin
         for (int i = 0; i < 32; i++) ram[i] <= (i == 3) ? 32'h8899_AABB : 32'h0000_0000;
         ram_loaded <= 1'b1;
      end else if (mem_we) begin
         ram[mem_addr[6:2]] <= mem_wdata;
      end
   end
   assign mem_rdata = ram[mem_addr[6:2]];

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Reference state and expectations, written by the stimulus process only.
   logic [31:0] ref_mem [0:31];
   logic        mon_en = 1'b0, busy = 1'b0, no_rsp = 1'b0, post_rst = 1'b0, tmo = 1'b0;
   logic        exp_fault, exp_writes, exp_store, lit_en;
   logic [31:0] exp_rdata, exp_word, exp_maddr, lit_val;
   logic [4:0]  exp_idx;
   int          exp_lat, t_acc;

   int n_checks = 0;
   int n_errors = 0;
   int we_seen  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Single compare process: every cycle after reset release.
   always @(negedge clk) begin
      if (mon_en) begin
         chk(busy ? "ready_busy" : "ready_idle", {31'd0, req_ready}, {31'd0, ~busy});
         if (mem_we) begin
            if (!(busy && exp_writes)) begin
               chk("mem_we_unexpected", {31'd0, mem_we}, 32'd0);
            end else begin
               chk("mem_addr", mem_addr, exp_maddr);
               chk("mem_wdata", mem_wdata, exp_word);
               we_seen++;
            end
         end
         if (rsp_valid) begin
            if (!busy || no_rsp) begin
               chk("rsp_valid_unexpected", {31'd0, rsp_valid}, 32'd0);
            end else begin
               chk("latency", 32'(cyc_cnt - t_acc + 1), 32'(exp_lat));
               chk("rsp_fault", {31'd0, rsp_fault}, {31'd0, exp_fault});
               chk("rsp_rdata", rsp_rdata, exp_rdata);
               chk("mem_we_count", 32'(we_seen), {31'd0, exp_writes});
               if (lit_en && exp_store) chk("ram_word_literal", ram[exp_idx], lit_val);
               if (lit_en && !exp_store) chk("rdata_literal", rsp_rdata, lit_val);
            end
            we_seen = 0;
         end
         if (!busy) begin
            int mism;
            mism = 0;
            for (int i = 0; i < 32; i++) if (ram[i] !== ref_mem[i]) mism++;
            chk("ram_vs_model", 32'(mism), 32'd0);
         end
         if (tmo) chk("rsp_timeout", {31'd0, tmo}, 32'd0);
         if (post_rst) begin
            chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
            chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            chk("rst_rsp_fault", {31'd0, rsp_fault}, 32'd0);
            chk("rst_rsp_rdata", rsp_rdata, 32'd0);
            chk("rst_mem_addr", mem_addr, 32'd0);
            chk("rst_mem_wdata", mem_wdata, 32'd0);
         end
      end
   end

   // Issue one request and derive its expected outcome from the architectural rules.
   task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic len, input logic [31:0] lit);
      logic [31:0] w, v, mask;
      int          sh;
      bit          got;
      exp_fault = (sz == 2'b11) || (sz == 2'b01 && addr[0]) ||
                  (sz == 2'b10 && addr[1:0] != 2'b00) || (addr[31:2] >= 30'd32);
      exp_idx    = addr[6:2];
      exp_maddr  = {addr[31:2], 2'b00};
      exp_store  = we;
      exp_writes = 1'b0;
      exp_rdata  = 32'd0;
      w          = ref_mem[addr[6:2]];
      exp_word   = w;
      sh         = int'(addr[1:0]) * 8;
      lit_en     = len;
      lit_val    = lit;
      if (exp_fault) begin
         exp_lat = 1;
      end else if (!we) begin
         exp_lat = 2;
         if (sz == 2'b00) begin
            v = (w >> sh) & 32'h0000_00FF;
            if (!uns && v >= 32'h0000_0080) v = v | 32'hFFFF_FF00;
         end else if (sz == 2'b01) begin
            v = (w >> sh) & 32'h0000_FFFF;
            if (!uns && v >= 32'h0000_8000) v = v | 32'hFFFF_0000;
         end else begin
            v = w;
         end
         exp_rdata = v;
      end else begin
         exp_writes = 1'b1;
         exp_lat    = (sz == 2'b10) ? 2 : 3;
         mask       = (sz == 2'b00) ? (32'h0000_00FF << sh) :
                      (sz == 2'b01) ? (32'h0000_FFFF << sh) : 32'hFFFF_FFFF;
         exp_word   = (w & ~mask) | ((wd << sh) & mask);
      end
      req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      t_acc     = cyc_cnt;
      busy      = 1'b1;
      got       = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         tmo = 1'b1;
         @(negedge clk); #1;
         tmo = 1'b0;
      end
      @(posedge clk); #1;
      busy = 1'b0;
      if (!exp_fault && we) ref_mem[addr[6:2]] = exp_word;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) ref_mem[i] = (i == 3) ? 32'h8899_AABB : 32'h0000_0000;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1; rst = 1'b0; mon_en = 1'b1; post_rst = 1'b1;
      @(posedge clk); #1; post_rst = 1'b0;

      // Loads of the preloaded word 0x8899AABB
      issue(1'b0, 2'b00, 1'b0, 32'h0F, 32'd0, 1'b1, 32'hFFFF_FF88);
      issue(1'b0, 2'b00, 1'b1, 32'h0C, 32'd0, 1'b1, 32'h0000_00BB);
      issue(1'b0, 2'b01, 1'b1, 32'h0E, 32'd0, 1'b1, 32'h0000_8899);
      issue(1'b0, 2'b01, 1'b0, 32'h0E, 32'd0, 1'b1, 32'hFFFF_8899);
      issue(1'b0, 2'b10, 1'b0, 32'h0C, 32'd0, 1'b1, 32'h8899_AABB);
      // Sub-word read-modify-write
      issue(1'b1, 2'b00, 1'b0, 32'h0D, 32'h0000_0055, 1'b1, 32'h8899_55BB);
      issue(1'b1, 2'b01, 1'b0, 32'h0E, 32'h0000_1234, 1'b1, 32'h1234_55BB);
      issue(1'b0, 2'b00, 1'b0, 32'h0D, 32'd0, 1'b1, 32'h0000_0055);
      // Faults: misaligned word, misaligned half, reserved size, out of range
      issue(1'b1, 2'b10, 1'b0, 32'h0E, 32'hCAFE_F00D, 1'b0, 32'd0);
      issue(1'b0, 2'b01, 1'b0, 32'h0D, 32'd0, 1'b0, 32'd0);
      issue(1'b0, 2'b11, 1'b0, 32'h0C, 32'd0, 1'b0, 32'd0);
      issue(1'b0, 2'b10, 1'b0, 32'h80, 32'd0, 1'b0, 32'd0);
      // Back-to-back store then load
      issue(1'b1, 2'b10, 1'b0, 32'h00, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF);
      issue(1'b0, 2'b10, 1'b0, 32'h00, 32'd0, 1'b1, 32'hDEAD_BEEF);
      // Highest legal word
      issue(1'b0, 2'b10, 1'b0, 32'h7C, 32'd0, 1'b1, 32'h0000_0000);
      issue(1'b1, 2'b00, 1'b0, 32'h7F, 32'h0000_00A5, 1'b1, 32'hA500_0000);
      issue(1'b0, 2'b00, 1'b0, 32'h7F, 32'd0, 1'b1, 32'hFFFF_FFA5);
      issue(1'b0, 2'b10, 1'b0, 32'h80, 32'd0, 1'b0, 32'd0);

      // Reset while an SB sits in its write cycle: nothing may be written or answered
      exp_writes = 1'b0; exp_store = 1'b1; no_rsp = 1'b1;
      req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h0D;
      req_wdata = 32'h0000_0077; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; busy = 1'b1; t_acc = cyc_cnt;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; busy = 1'b0; no_rsp = 1'b0; post_rst = 1'b1;
      @(posedge clk); #1;
      post_rst = 1'b0;
      issue(1'b0, 2'b10, 1'b0, 32'h0C, 32'd0, 1'b1, 32'h1234_55BB);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
